// File: rtl/dese_wide.sv
// Wide deserializer: packs LANE-bit beats into WIDTH-bit words, index 0 first,
// with a one-word output register and slice-end flushing of partial words.
module dese_wide #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned LANE  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_en,
    input  logic [0:LANE-1]          sign_in,
    input  logic                     sign_wr,
    input  logic                     slice_end,
    output logic                     sign_rdy,
    output logic [0:WIDTH-1]         sign_out,
    output logic [$clog2(WIDTH):0]   size_out,
    output logic                     des_wr,
    output logic                     last_wr,
    input  logic                     out_ack
);

    localparam int unsigned CW    = $clog2(WIDTH) + 1;
    localparam int unsigned BEATS = WIDTH / LANE;

    typedef enum logic [1:0] {FILL, HOLD_FULL, HOLD_LAST} acc_state_e;
    typedef enum logic [1:0] {EMPTY, WORD, LAST} out_state_e;

    acc_state_e          acc_state, acc_state_d;
    out_state_e          out_state, out_state_d;
    logic [0:WIDTH-1]    acc_word, acc_word_d;
    logic [CW-1:0]       acc_cnt, acc_cnt_d;
    logic [0:WIDTH-1]    out_word_d;
    logic [CW-1:0]       out_size_d;
    logic [0:WIDTH-1]    merged;
    logic [CW-1:0]       merged_cnt;
    logic                out_busy;
    logic                out_free;

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_state <= FILL;
            out_state <= EMPTY;
            acc_word  <= '0;
            acc_cnt   <= '0;
            sign_out  <= '0;
            size_out  <= '0;
            sign_rdy  <= 1'b1;
            des_wr    <= 1'b0;
            last_wr   <= 1'b0;
        end else begin
            acc_state <= acc_state_d;
            out_state <= out_state_d;
            acc_word  <= acc_word_d;
            acc_cnt   <= acc_cnt_d;
            sign_out  <= out_word_d;
            size_out  <= out_size_d;
            sign_rdy  <= (acc_state_d == FILL);
            des_wr    <= (out_state_d == WORD);
            last_wr   <= (out_state_d == LAST);
        end
    end

    // Next-state logic for accumulator and output register
    always_comb begin
        acc_state_d = acc_state;
        out_state_d = out_state;
        acc_word_d  = acc_word;
        acc_cnt_d   = acc_cnt;
        out_word_d  = sign_out;
        out_size_d  = size_out;

        out_busy = (out_state != EMPTY);
        out_free = !out_busy || (clk_en && out_ack);

        // Current word with this cycle's beat folded in (bits beyond count stay 0)
        merged = acc_word;
        if (sign_wr) begin
            for (int unsigned b = 0; b < BEATS; b++) begin
                if (acc_cnt == CW'(b * LANE)) begin
                    merged[b*LANE +: LANE] = sign_in;
                end
            end
        end
        merged_cnt = acc_cnt + (sign_wr ? CW'(LANE) : CW'(0));

        if (clk_en) begin
            if (out_busy && out_ack) begin
                out_state_d = EMPTY;
                out_word_d  = '0;
                out_size_d  = '0;
            end

            case (acc_state)
                FILL: begin
                    if (slice_end) begin
                        if (out_free) begin
                            out_state_d = LAST;
                            out_word_d  = merged;
                            out_size_d  = merged_cnt;
                            acc_word_d  = '0;
                            acc_cnt_d   = '0;
                        end else begin
                            acc_word_d  = merged;
                            acc_cnt_d   = merged_cnt;
                            acc_state_d = HOLD_LAST;
                        end
                    end else if (sign_wr) begin
                        if (merged_cnt == CW'(WIDTH)) begin
                            if (out_free) begin
                                out_state_d = WORD;
                                out_word_d  = merged;
                                out_size_d  = CW'(WIDTH);
                                acc_word_d  = '0;
                                acc_cnt_d   = '0;
                            end else begin
                                acc_word_d  = merged;
                                acc_cnt_d   = merged_cnt;
                                acc_state_d = HOLD_FULL;
                            end
                        end else begin
                            acc_word_d = merged;
                            acc_cnt_d  = merged_cnt;
                        end
                    end
                end
                HOLD_FULL, HOLD_LAST: begin
                    if (out_free) begin
                        out_state_d = (acc_state == HOLD_FULL) ? WORD : LAST;
                        out_word_d  = acc_word;
                        out_size_d  = acc_cnt;
                        acc_word_d  = '0;
                        acc_cnt_d   = '0;
                        acc_state_d = FILL;
                    end
                end
                default: acc_state_d = FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_dese_wide.sv
// Scoreboard bench for dese_wide: a 64x1 instance and a 32x4 instance side by side.
module tb_dese_wide;

    typedef struct {
        logic [255:0] w;
        int unsigned  sz;
        bit           last;
    } exp_t;

    exp_t q64[$];
    exp_t q32[$];
    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_en = 1'b1;

    logic [0:0]  in64 = '0;
    logic        wr64 = 1'b0, se64 = 1'b0, ack64 = 1'b1;
    logic        rdy64, des64, last64;
    logic [0:63] out64;
    logic [6:0]  size64;

    logic [0:3]  in32 = '0;
    logic        wr32 = 1'b0, se32 = 1'b0, ack32 = 1'b1;
    logic        rdy32, des32, last32;
    logic [0:31] out32;
    logic [5:0]  size32;

    dese_wide #(.WIDTH(64), .LANE(1)) dut64 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .sign_in(in64), .sign_wr(wr64),
        .slice_end(se64), .sign_rdy(rdy64), .sign_out(out64), .size_out(size64),
        .des_wr(des64), .last_wr(last64), .out_ack(ack64)
    );

    dese_wide #(.WIDTH(32), .LANE(4)) dut32 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .sign_in(in32), .sign_wr(wr32),
        .slice_end(se32), .sign_rdy(rdy32), .sign_out(out32), .size_out(size32),
        .des_wr(des32), .last_wr(last32), .out_ack(ack32)
    );

    always #5 clk = ~clk;

    // Scoreboard: compare each word in the cycle the consumer acknowledges it
    always @(negedge clk) begin
        if (rst && clk_en && ack64 && (des64 || last64)) begin
            checks++;
            if (q64.size() == 0) begin
                errors++;
                $display("FAIL sb64 unexpected word: got %h size %0d last %0d", out64, size64, last64);
            end else begin
                exp_t e;
                e = q64.pop_front();
                if (256'(out64) !== e.w || 32'(size64) !== e.sz || last64 !== e.last || des64 === last64) begin
                    errors++;
                    $display("FAIL sb64 word: got %h size %0d des %0d last %0d, exp %h size %0d last %0d",
                             out64, size64, des64, last64, e.w[63:0], e.sz, e.last);
                end
            end
        end
        if (rst && clk_en && ack32 && (des32 || last32)) begin
            checks++;
            if (q32.size() == 0) begin
                errors++;
                $display("FAIL sb32 unexpected word: got %h size %0d last %0d", out32, size32, last32);
            end else begin
                exp_t e;
                e = q32.pop_front();
                if (256'(out32) !== e.w || 32'(size32) !== e.sz || last32 !== e.last || des32 === last32) begin
                    errors++;
                    $display("FAIL sb32 word: got %h size %0d des %0d last %0d, exp %h size %0d last %0d",
                             out32, size32, des32, last32, e.w[31:0], e.sz, e.last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push64(input logic [0:63] w, input int unsigned sz, input bit last);
        exp_t e;
        e.w = 256'(w); e.sz = sz; e.last = last;
        q64.push_back(e);
    endtask

    task automatic push32(input logic [0:31] w, input int unsigned sz, input bit last);
        exp_t e;
        e.w = 256'(w); e.sz = sz; e.last = last;
        q32.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100 && (q64.size() != 0 || q32.size() != 0); i++) tick();
        checks++;
        if (q64.size() != 0 || q32.size() != 0) begin
            errors++;
            $display("FAIL %s drain: pending64 %0d pending32 %0d, want 0", name, q64.size(), q32.size());
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        repeat (2) tick();
        checks++;
        if (rdy64 !== 1'b1 || des64 !== 1'b0 || last64 !== 1'b0 || out64 !== '0 || size64 !== '0) begin
            errors++;
            $display("FAIL reset64: rdy %b des %b last %b out %h size %0d", rdy64, des64, last64, out64, size64);
        end
        checks++;
        if (rdy32 !== 1'b1 || des32 !== 1'b0 || last32 !== 1'b0 || out32 !== '0 || size32 !== '0) begin
            errors++;
            $display("FAIL reset32: rdy %b des %b last %b out %h size %0d", rdy32, des32, last32, out32, size32);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_alternating();
        logic [0:63] e;
        e = '0;
        for (int k = 0; k < 27; k++) e[k] = (k % 2 == 0);
        push64(64'hAAAA_AAAA_AAAA_AAAA, 64, 1'b0);
        push64(e, 27, 1'b1);
        ack64 = 1'b1;
        for (int i = 0; i < 91; i++) begin
            wr64 = 1'b1; in64 = 1'((i % 2) == 0);
            tick();
            if (i == 63) begin
                checks++;
                if (des64 !== 1'b1) begin
                    errors++;
                    $display("FAIL alt latency: des_wr %b, want 1", des64);
                end
            end
        end
        wr64 = 1'b0; se64 = 1'b1;
        tick();
        se64 = 1'b0;
        wait_drain("alt");
    endtask

    task automatic test_backpressure();
        logic [0:129] bits;
        logic [0:63]  w1, w2;
        for (int i = 0; i < 130; i++) bits[i] = 1'($urandom);
        w1 = bits[0:63];
        w2 = bits[64:127];
        push64(w1, 64, 1'b0);
        push64(w2, 64, 1'b0);
        ack64 = 1'b0;
        for (int i = 0; i < 130; i++) begin
            wr64 = 1'b1; in64 = bits[i];
            tick();
            if (i == 126 || i == 127) begin
                checks++;
                if (rdy64 !== 1'(i == 126)) begin
                    errors++;
                    $display("FAIL bp sign_rdy after beat %0d: got %b want %b", i + 1, rdy64, 1'(i == 126));
                end
            end
        end
        wr64 = 1'b0;
        repeat (2) tick();
        checks++;
        if (des64 !== 1'b1 || out64 !== w1) begin
            errors++;
            $display("FAIL bp hold word1: des %b out %h want %h", des64, out64, w1);
        end
        ack64 = 1'b1;
        tick();
        checks++;
        if (des64 !== 1'b1 || out64 !== w2) begin
            errors++;
            $display("FAIL bp back_to_back word2: des %b out %h want %h", des64, out64, w2);
        end
        tick();
        checks++;
        if (rdy64 !== 1'b1) begin
            errors++;
            $display("FAIL bp sign_rdy release: got %b want 1", rdy64);
        end
        wait_drain("bp");
    endtask

    task automatic test_empty_slice();
        push64('0, 0, 1'b1);
        se64 = 1'b1;
        tick();
        se64 = 1'b0;
        checks++;
        if (last64 !== 1'b1 || des64 !== 1'b0 || out64 !== '0 || size64 !== '0) begin
            errors++;
            $display("FAIL empty_slice: last %b des %b out %h size %0d", last64, des64, out64, size64);
        end
        wait_drain("empty_slice");
    endtask

    task automatic test_end_on_full();
        logic [0:63] bits;
        for (int i = 0; i < 64; i++) bits[i] = 1'($urandom);
        push64(bits, 64, 1'b1);
        for (int i = 0; i < 64; i++) begin
            wr64 = 1'b1; in64 = bits[i]; se64 = 1'(i == 63);
            tick();
        end
        wr64 = 1'b0; se64 = 1'b0;
        checks++;
        if (last64 !== 1'b1 || des64 !== 1'b0) begin
            errors++;
            $display("FAIL end_on_full: last %b des %b, want 1/0", last64, des64);
        end
        wait_drain("end_on_full");
    endtask

    task automatic test_clk_en();
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr64 = 1'b1; in64 = 1'b1; se64 = 1'(i == 4);
            tick();
        end
        wr64 = 1'b0; se64 = 1'b0;
        checks++;
        if (rdy64 !== 1'b1 || des64 !== 1'b0 || last64 !== 1'b0) begin
            errors++;
            $display("FAIL clk_en frozen: rdy %b des %b last %b", rdy64, des64, last64);
        end
        clk_en = 1'b1;
        push64('0, 0, 1'b1);
        se64 = 1'b1;
        tick();
        se64 = 1'b0;
        wait_drain("clk_en");
    endtask

    task automatic test_lane4();
        push32(32'h9999_9999, 32, 1'b0);
        push32(32'h9000_0000, 4, 1'b1);
        for (int i = 0; i < 9; i++) begin
            wr32 = 1'b1; in32 = 4'b1001;
            tick();
            if (i == 7) begin
                checks++;
                if (des32 !== 1'b1) begin
                    errors++;
                    $display("FAIL lane4 latency: des_wr %b, want 1", des32);
                end
            end
        end
        wr32 = 1'b0; se32 = 1'b1;
        tick();
        se32 = 1'b0;
        wait_drain("lane4");
    endtask

    task automatic test_reset_mid_word();
        for (int i = 0; i < 30; i++) begin
            wr64 = 1'b1; in64 = 1'b0;
            tick();
        end
        wr64 = 1'b0;
        clk_en = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (rdy64 !== 1'b1 || des64 !== 1'b0 || last64 !== 1'b0 || out64 !== '0 || size64 !== '0) begin
            errors++;
            $display("FAIL mid_reset outputs: rdy %b des %b last %b out %h size %0d", rdy64, des64, last64, out64, size64);
        end
        rst = 1'b1;
        tick();
        clk_en = 1'b1;
        push64('1, 64, 1'b0);
        for (int i = 0; i < 64; i++) begin
            wr64 = 1'b1; in64 = 1'b1;
            tick();
            if (i == 62 || i == 63) begin
                checks++;
                if (des64 !== 1'(i == 63)) begin
                    errors++;
                    $display("FAIL mid_reset word timing after beat %0d: des %b want %b", i + 1, des64, 1'(i == 63));
                end
            end
        end
        wr64 = 1'b0;
        wait_drain("mid_reset");
    endtask

    initial begin
        test_reset();
        test_alternating();
        test_backpressure();
        test_empty_slice();
        test_end_on_full();
        test_clk_en();
        test_lane4();
        test_reset_mid_word();
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
